// File: rtl/conv_ctrl_if.sv
// Start/busy/done handshake between the convolution sequencer and its requester.
interface conv_ctrl_if;
  logic start;
  logic busy;
  logic done;

  modport master (output start, input busy, input done);
  modport slave  (input start, output busy, output done);
endinterface

// File: rtl/conv_controller.sv
// Sequencing FSM for the 2-D convolution datapath: filter load, row streaming, MACs, result packing, flush.
// Optional CONV_CTRL_DBG_EN adds dbg_state/dbg_cycles observation ports.
module conv_controller #(
  parameter int unsigned ROWS = 13,
  parameter int unsigned COLS = 13
) (
  input  logic       clk,
  input  logic       rst,
  conv_ctrl_if.slave hs,
  input  logic       co_cntr4_filter,
  input  logic       co_cntr16_img,
  input  logic       co_row_cntr,
  input  logic       co_cntr16,
  input  logic       co_col_cntr,
  input  logic       co_cntr_reg4,
  input  logic       co_cntr13,
  input  logic       co_cntr43,
  output logic       mem_en,
  output logic       wr_file,
  output logic       filter_wr_en,
  output logic       img_wr_en,
  output logic       img_slice_en,
  output logic       acc_en,
  output logic       rst_acc,
  output logic       res_buffer_en,
  output logic       rst_res_reg,
  output logic       cntr4_filter_en,
  output logic       cntr16_img_en,
  output logic       row_cntr_en,
  output logic       col_cntr_en,
  output logic       cntr16_en,
  output logic       cntr_reg4_en,
  output logic       cntr43_en,
  output logic       cntr13_en,
  output logic       inc_en,
  output logic       inc_ld,
  output logic       adr_sel,
  output logic [1:0] mem_offset_sel
`ifdef CONV_CTRL_DBG_EN
  ,
  output logic [3:0]  dbg_state,
  output logic [15:0] dbg_cycles
`endif
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LD_F     = 4'd1,
    INIT_X   = 4'd2,
    LD_I     = 4'd3,
    SLICE    = 4'd4,
    MAC      = 4'd5,
    STORE    = 4'd6,
    WRITE    = 4'd7,
    NEXT_ROW = 4'd8,
    FLUSH    = 4'd9,
    FIN      = 4'd10
  } state_t;

  // A partial final word exists only when the result count is not a multiple of four.
  localparam logic HAS_TAIL = ((ROWS * COLS) % 4) != 0;

  state_t     state, nxt;
  logic       col_done;
  logic [1:0] shadow;
  logic       flush_wr;

  assign flush_wr = (state == FLUSH) && HAS_TAIL && (shadow != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // shadow mirrors the datapath's cntr_reg4 so FLUSH knows whether a partial word is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      col_done <= 1'b0;
      shadow   <= '0;
    end else if (state == STORE) begin
      col_done <= co_col_cntr;
      shadow   <= shadow + 2'd1;
    end else if (state == FLUSH || (state == IDLE && hs.start)) begin
      shadow   <= '0;
    end
  end

  always_comb begin
    nxt             = state;
    hs.busy         = (state != IDLE);
    hs.done         = 1'b0;
    mem_en          = 1'b0;
    wr_file         = 1'b0;
    filter_wr_en    = 1'b0;
    img_wr_en       = 1'b0;
    img_slice_en    = 1'b0;
    acc_en          = 1'b0;
    rst_acc         = 1'b0;
    res_buffer_en   = 1'b0;
    rst_res_reg     = 1'b0;
    cntr4_filter_en = 1'b0;
    cntr16_img_en   = 1'b0;
    row_cntr_en     = 1'b0;
    col_cntr_en     = 1'b0;
    cntr16_en       = 1'b0;
    cntr_reg4_en    = 1'b0;
    cntr43_en       = 1'b0;
    cntr13_en       = 1'b0;
    inc_en          = 1'b0;
    inc_ld          = 1'b0;
    adr_sel         = 1'b0;
    mem_offset_sel  = 2'd0;
    case (state)
      IDLE: if (hs.start) nxt = LD_F;
      LD_F: begin
        filter_wr_en    = 1'b1;
        cntr4_filter_en = 1'b1;
        if (co_cntr4_filter) nxt = INIT_X;
      end
      INIT_X: begin
        inc_ld = 1'b1;
        nxt    = LD_I;
      end
      LD_I: begin
        adr_sel        = 1'b1;
        mem_offset_sel = 2'd1;
        img_wr_en      = 1'b1;
        cntr16_img_en  = 1'b1;
        if (co_cntr16_img) nxt = SLICE;
      end
      SLICE: begin
        img_slice_en = 1'b1;
        row_cntr_en  = 1'b1;
        if (co_row_cntr) nxt = MAC;
      end
      MAC: begin
        acc_en    = 1'b1;
        cntr16_en = 1'b1;
        if (co_cntr16) nxt = STORE;
      end
      STORE: begin
        res_buffer_en = 1'b1;
        cntr_reg4_en  = 1'b1;
        rst_acc       = 1'b1;
        col_cntr_en   = 1'b1;
        if (co_cntr_reg4)     nxt = WRITE;
        else if (co_col_cntr) nxt = NEXT_ROW;
        else                  nxt = SLICE;
      end
      WRITE: begin
        mem_en         = 1'b1;
        mem_offset_sel = 2'd2;
        cntr43_en      = 1'b1;
        rst_res_reg    = 1'b1;
        nxt            = col_done ? NEXT_ROW : SLICE;
      end
      NEXT_ROW: begin
        inc_en    = 1'b1;
        cntr13_en = 1'b1;
        nxt       = co_cntr13 ? FLUSH : LD_I;
      end
      FLUSH: begin
        if (flush_wr) begin
          mem_en         = 1'b1;
          mem_offset_sel = 2'd2;
          cntr43_en      = 1'b1;
          rst_res_reg    = 1'b1;
        end
        nxt = FIN;
      end
      FIN: begin
        wr_file = 1'b1;
        hs.done = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // The result memory must not be full before the final write of a run.
  a_no_result_overflow: assert property (@(posedge clk) disable iff (rst)
    !(state == WRITE && co_cntr43));

`ifdef CONV_CTRL_DBG_EN
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst)                          dbg_cycles <= '0;
    else if (state == IDLE && hs.start) dbg_cycles <= '0;
    else if (state != IDLE)           dbg_cycles <= dbg_cycles + 16'd1;
  end
`endif

endmodule

// File: doc/conv_controller.md
# conv_controller

Sequencing FSM for the 2-D convolution datapath. It issues every enable/select the datapath needs:
- load the 4-word filter;
- stream 13 image rows through the image buffer;
- run 169 16-tap MACs;
- pack results four per word;
- write 43 result words at base `z`, then flush the memory file.

It sits beside the datapath in the top level, consumes only the datapath carry-outs, and answers a `start`/`done` handshake.

## Interface
Parameters:
- `ROWS`, 13: image rows processed (`cntr13` span).
- `COLS`, 13: output columns per row (`col_cntr` span).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high. Shared with the datapath.
- `start`, input, 1: begin a convolution. Sampled only in `IDLE`.
- `co_cntr4_filter`, `co_cntr16_img`, `co_row_cntr`, `co_cntr16`, `co_col_cntr`, `co_cntr_reg4`, `co_cntr13`, `co_cntr43`, input, 1 each: datapath carry-outs. Each is high while its counter holds its terminal value.
- `busy`, output, 1: high in every state except `IDLE`.
- `done`, output, 1: one-cycle pulse on completion.
- `mem_en`, `wr_file`, `filter_wr_en`, `img_wr_en`, `img_slice_en`, `acc_en`, `rst_acc`, `res_buffer_en`, `rst_res_reg`, output, 1 each: datapath storage controls.
- `cntr4_filter_en`, `cntr16_img_en`, `row_cntr_en`, `col_cntr_en`, `cntr16_en`, `cntr_reg4_en`, `cntr43_en`, `cntr13_en`, `inc_en`, `inc_ld`, output, 1 each: counter controls.
- `adr_sel`, output, 1: read-address source. 0 selects the filter counter; 1 selects the image counter.
- `mem_offset_sel`, output, 2: memory base. 0 selects `y` (filter), 1 selects `x_offset` (image row), 2 selects `z` (result).

## Operation
- Moore FSM. Every output is a pure function of the registered state plus the carry-outs. Outputs not listed for a state are 0.
- `IDLE`: waits for `start=1`, then goes to `LD_F`.
- `LD_F` (4 cycles): `adr_sel=0`, `mem_offset_sel=0`, `filter_wr_en`, `cntr4_filter_en`. Exits to `INIT_X` when `co_cntr4_filter=1`.
- `INIT_X` (1 cycle): `inc_ld` loads the image base `x`. Goes to `LD_I`.
- `LD_I` (16 cycles): `adr_sel=1`, `mem_offset_sel=1`, `img_wr_en`, `cntr16_img_en`. Exits to `SLICE` on `co_cntr16_img`.
- `SLICE` (4 cycles): `img_slice_en`, `row_cntr_en`. Exits to `MAC` on `co_row_cntr`.
- `MAC` (16 cycles): `acc_en`, `cntr16_en`. Exits to `STORE` on `co_cntr16`.
- `STORE` (1 cycle): `res_buffer_en`, `cntr_reg4_en`, `rst_acc`, `col_cntr_en`. The buffer captures `acc_out[11:4]` on the same edge that clears the accumulator. Next state is decided in this priority order:
  1. `co_cntr_reg4=1`: go to `WRITE`.
  2. `co_col_cntr=1`: go to `NEXT_ROW`.
  3. Otherwise: go to `SLICE`.
- `WRITE` (1 cycle): `mem_en`, `mem_offset_sel=2`, `cntr43_en`, `rst_res_reg`.
  - If the column just stored was the last of its row (`co_col_cntr` was seen in `STORE`; latched in a 1-bit flag), go to `NEXT_ROW`.
  - Otherwise go to `SLICE`.
- `NEXT_ROW` (1 cycle): `inc_en` (x_offset += 4), `cntr13_en`.
  - If `co_cntr13=1`, go to `FLUSH`.
  - Otherwise go to `LD_I`.
- `FLUSH` (1 cycle): if `cntr_reg4` is nonzero (tracked by an internal 2-bit shadow count), assert `mem_en`, `mem_offset_sel=2`, `cntr43_en`, `rst_res_reg`. 169 mod 4 = 1, so exactly one partial word is written. Goes to `FIN`.
- `FIN` (1 cycle): `wr_file`, `done`. Goes to `IDLE`.
- `start` is ignored while `busy=1`.
- Reset: `rst=1` forces `IDLE` and clears the `col_done` flag and the shadow count on the next edge. All outputs are 0 in `IDLE`. Reset mid-run aborts with no flush, and the datapath counters reset alongside.
- If `co_cntr43` is seen with `mem_en` while more writes remain (result overflow), the FSM still completes normally. This is a verification check, not a recovery path.

## Timing
- `start` high at edge N gives `busy=1` and `filter_wr_en=1` from cycle N+1.
- Row cost: 16 + 13×21 + (number of `WRITE`s in that row) + 1.
- Total run: 4 + 1 + 13×(16 + 273 + 1) + 42 `WRITE` + 1 `FLUSH` + 1 `FIN` = 3819 cycles from the first `LD_F` cycle to `done`.
- `done` and `wr_file` are high for exactly 1 cycle, coincident. `busy` falls the cycle after.
- Back-to-back: `start` held high in the cycle after `done` restarts immediately.

## Configuration
- `CONV_CTRL_DBG_EN` defined: adds output port `dbg_state` [3:0] carrying the encoded FSM state, with `IDLE`=0 through `FIN`=10 in the order listed above. Also adds `dbg_cycles` [15:0], which counts `busy` cycles, clears on `start` accepted, and holds after `done`.
- Undefined: neither port exists. Behaviour is otherwise identical.

## Test plan
- Reset, then pulse `start` -> `filter_wr_en` high for exactly 4 cycles, then `inc_ld` for 1 cycle.
- Full run -> `done` exactly 3819 cycles after the first `LD_F` cycle. Counts: `img_wr_en` 208, `acc_en` 2704, `rst_acc` 169, `mem_en` 43, `inc_en` 13, `wr_file` 1.
- Column-end and 4th store in the same `STORE` (the 52nd result) -> `WRITE` then `NEXT_ROW`, with no extra `SLICE` in between.
- Final row -> single `FLUSH` `mem_en`, `rst_res_reg`; `co_cntr43` asserted during that write.
- `rst` asserted during `MAC` of row 5 -> outputs all 0 next cycle; a new `start` reproduces the full 3819-cycle run.
- `start` toggled while busy -> no effect on the cycle count or on any enable.
